alu4_result_stage: RTL and testbench

Registered output stage directly downstream of the ALU's 8-to-1 result multiplexer bank. Captures the selected WIDTH-bit result plus adder carry/overflow and generates NZCV flags. Decouples the combinational ALU from the consumer through a 2-entry skid buffer with valid/ready handshakes on both sides.

---
 rtl/alu4_result_stage_if.sv | 28 ++
 rtl/alu4_result_stage.sv | 114 +++++++++++
 tb/tb_alu4_result_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu4_result_stage_if.sv
// Handshake bundle between the ALU result mux bank, the registered result stage and its consumer.
// The stage connects through the slave modport; the producer/consumer side uses master.
interface alu4_result_stage_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_op;
    logic [3:0]       out_flags;
    logic [7:0]       op_count;

    modport slave (
        input  in_valid, in_op, in_result, in_carry, in_ovf, out_ready,
        output in_ready, out_valid, out_result, out_op, out_flags, op_count
    );

    modport master (
        output in_valid, in_op, in_result, in_carry, in_ovf, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_flags, op_count
    );
endinterface

// File: rtl/alu4_result_stage.sv
// Registered ALU result stage: NZCV flag generation plus a 2-entry skid buffer.
// Optional macro ALU4_OPCOUNT_EN builds a saturating 8-bit delivered-transfer counter.
module alu4_result_stage #(
    parameter int         WIDTH      = 4,
    parameter logic [7:0] ARITH_MASK = 8'b1100_0000
) (
    input  logic                clk,
    input  logic                reset,
    alu4_result_stage_if.slave  bus
);
    localparam int EW = WIDTH + 7;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] head_q, head_d;
    logic [EW-1:0] skid_q, skid_d;
    logic [EW-1:0] new_entry;
    logic [3:0]    new_flags;
    logic          arith;
    logic          in_ready;
    logic          out_valid;
    logic          accept;
    logic          deliver;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign deliver   = out_valid & bus.out_ready;

    // Carry and overflow only mean something for adder opcodes.
    always_comb begin
        arith     = ARITH_MASK[bus.in_op];
        new_flags = {bus.in_result[WIDTH-1], (bus.in_result == '0),
                     arith & bus.in_carry, arith & bus.in_ovf};
        new_entry = {bus.in_result, bus.in_op, new_flags};
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    head_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = TWO;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = head_q[EW-1 -: WIDTH];
    assign bus.out_op     = head_q[6:4];
    assign bus.out_flags  = head_q[3:0];

`ifdef ALU4_OPCOUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (deliver && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.op_count = count_q;
`else
    assign bus.op_count = 8'd0;
`endif
endmodule

// File: tb/tb_alu4_result_stage.sv
// Self-checking bench for alu4_result_stage: directed test-plan sequences plus random traffic
// compared against a queue-based FIFO model of capacity two.
module tb_alu4_result_stage;
    localparam int         WIDTH      = 4;
    localparam logic [7:0] ARITH_MASK = 8'b1100_0000;

    typedef struct {
        int res;
        int op;
        int flg;
    } entry_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    entry_t model_q[$];
    entry_t last_head;
    int     model_count;
    int     delivered_log[$];

    alu4_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu4_result_stage #(
        .WIDTH      (WIDTH),
        .ARITH_MASK (ARITH_MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int refFlags(input int op, input int res, input int c, input int o);
        int arith;
        int n;
        int z;
        arith = (ARITH_MASK >> op) % 2;
        n     = (res >= (1 << (WIDTH - 1))) ? 1 : 0;
        z     = (res == 0) ? 1 : 0;
        return n * 8 + z * 4 + (arith * c) * 2 + (arith * o);
    endfunction

    task automatic compareModel();
        entry_t exp_head;
        int     exp_count;
        exp_head = (model_q.size() > 0) ? model_q[0] : last_head;
`ifdef ALU4_OPCOUNT_EN
        exp_count = model_count;
`else
        exp_count = 0;
`endif
        checkOutput("in_ready",   32'(bus.in_ready),   32'(model_q.size() < 2));
        checkOutput("out_valid",  32'(bus.out_valid),  32'(model_q.size() > 0));
        checkOutput("out_result", 32'(bus.out_result), 32'(exp_head.res));
        checkOutput("out_op",     32'(bus.out_op),     32'(exp_head.op));
        checkOutput("out_flags",  32'(bus.out_flags),  32'(exp_head.flg));
        checkOutput("op_count",   32'(bus.op_count),   32'(exp_count));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare at the falling edge.
    task automatic applyStimulus(input bit rst, input bit v, input int op, input int res,
                                 input bit c, input bit o, input bit rdy);
        bit     do_accept;
        bit     do_deliver;
        entry_t e;
        reset         = rst;
        bus.in_valid  = v;
        bus.in_op     = 3'(op);
        bus.in_result = WIDTH'(res);
        bus.in_carry  = c;
        bus.in_ovf    = o;
        bus.out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            last_head   = '{0, 0, 0};
            model_count = 0;
        end else begin
            do_deliver = (model_q.size() > 0) && rdy;
            do_accept  = v && (model_q.size() < 2);
            if (do_deliver) begin
                last_head = model_q.pop_front();
                delivered_log.push_back(last_head.res);
                if (model_count < 255) model_count++;
            end
            if (do_accept) begin
                e = '{res, op, refFlags(op, res, int'(c), int'(o))};
                model_q.push_back(e);
            end
        end
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        model_count = 0;
        last_head   = '{0, 0, 0};

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 7, 15, 1, 1, 1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset_result",    32'(bus.out_result), 32'd0);

        applyStimulus(0, 1, 3'b110, 4'b1000, 1, 1, 1);
        checkOutput("arith_valid",  32'(bus.out_valid),  32'd1);
        checkOutput("arith_result", 32'(bus.out_result), 32'd8);
        checkOutput("arith_flags",  32'(bus.out_flags),  32'b1011);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("drain_empty", 32'(bus.out_valid), 32'd0);
        checkOutput("hold_flags",  32'(bus.out_flags), 32'b1011);

        applyStimulus(0, 1, 3'b010, 0, 1, 1, 1);
        checkOutput("logic_flags", 32'(bus.out_flags), 32'b0100);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        delivered_log.delete();
        applyStimulus(0, 1, 3'b000, 1, 0, 0, 0);
        applyStimulus(0, 1, 3'b000, 2, 0, 0, 0);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(0, 1, 3'b000, 3, 0, 0, 0);
        applyStimulus(0, 1, 3'b000, 3, 0, 0, 0);
        checkOutput("held_result", 32'(bus.out_result), 32'd1);
        applyStimulus(0, 1, 3'b000, 3, 0, 0, 1);
        applyStimulus(0, 1, 3'b000, 3, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("order_count", 32'(delivered_log.size()), 32'd3);
        if (delivered_log.size() == 3) begin
            checkOutput("order_0", 32'(delivered_log[0]), 32'd1);
            checkOutput("order_1", 32'(delivered_log[1]), 32'd2);
            checkOutput("order_2", 32'(delivered_log[2]), 32'd3);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 3'b111, i, i % 2, 0, 1);
            checkOutput("stream_in_ready",  32'(bus.in_ready),  32'd1);
            checkOutput("stream_out_valid", 32'(bus.out_valid), 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        delivered_log.delete();
        applyStimulus(0, 1, 3'b001, 5, 0, 0, 0);
        applyStimulus(0, 1, 3'b001, 6, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst2_out_valid", 32'(bus.out_valid),  32'd0);
        checkOutput("rst2_in_ready",  32'(bus.in_ready),   32'd1);
        checkOutput("rst2_result",    32'(bus.out_result), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst2_no_deliver", 32'(delivered_log.size()), 32'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));
        end

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 310; i++) begin
            applyStimulus(0, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1, 0, 1);
        end
`ifdef ALU4_OPCOUNT_EN
        checkOutput("count_saturate", 32'(bus.op_count), 32'd255);
`else
        checkOutput("count_disabled", 32'(bus.op_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
